decode_scoreboard_rf: RTL and testbench

//   Parametrised decode-stage register file with a per-register pending-write scoreboard.

---
 rtl/decode_scoreboard_rf.sv | 110 +++++++++++
 tb/tb_decode_scoreboard_rf.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/decode_scoreboard_rf.sv
// Decode-stage register file with per-register pending-writer counters.
// Raises stall on RAW / pending-overflow hazards and bypasses same-cycle writeback data.
module decode_scoreboard_slot #(
  parameter int DW   = 16,
  parameter int MAXP = 3,
  parameter int CW   = $clog2(MAXP+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_hit,
  input  logic [DW-1:0] wb_data,
  input  logic          kill_hit,
  input  logic          inc,
  output logic [DW-1:0] q,
  output logic          busy,
  output logic          full,
  output logic          under
);
  logic [CW-1:0] cnt, eff;
  logic [CW:0]   cnt_x, dec;

  assign cnt_x = {1'b0, cnt};
  assign dec   = {{CW{1'b0}}, wb_hit} + {{CW{1'b0}}, kill_hit};
  assign under = dec > cnt_x;
  // eff is what remains outstanding once this cycle's retirements land
  assign eff   = under ? '0 : CW'(cnt_x - dec);
  assign busy  = eff != '0;
  assign full  = eff == CW'(MAXP);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      q   <= '0;
    end else begin
      cnt <= eff + CW'(inc);
      if (wb_hit) q <= wb_data;
    end
endmodule

module decode_scoreboard_rf #(
  parameter int DW       = 16,
  parameter int NREGS    = 8,
  parameter int MAXP     = 3,
  parameter int ZERO_REG = 0,
  parameter int AW       = $clog2(NREGS),
  parameter int CW       = $clog2(MAXP+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd1_sel,
  input  logic [AW-1:0] rd2_sel,
  input  logic          src1_used,
  input  logic          src2_used,
  output logic [DW-1:0] rd1_data,
  output logic [DW-1:0] rd2_data,
  input  logic          issue_valid,
  input  logic          issue_we,
  input  logic [AW-1:0] issue_dst,
  output logic          stall,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_sel,
  input  logic [DW-1:0] wb_data,
  input  logic          kill_valid,
  input  logic [AW-1:0] kill_sel,
  output logic          err
);
  localparam int NSLOT = 1 << AW;

  logic [NSLOT-1:0][DW-1:0] rf;
  logic [NSLOT-1:0]         busy, full, under, live;
  logic                     fire;

  // Slots past NREGS (and r0 when hardwired) are dead: read 0, never busy, ignore writes
  for (genvar r = 0; r < NSLOT; r++) begin : g_reg
    localparam logic [AW-1:0] IDX = AW'(r);
    if (r < NREGS && !(ZERO_REG != 0 && r == 0)) begin : g_live
      assign live[r] = 1'b1;
      decode_scoreboard_slot #(.DW(DW), .MAXP(MAXP), .CW(CW)) u_slot (
        .clk      (clk),
        .rst      (rst),
        .wb_hit   (wb_we && wb_sel == IDX),
        .wb_data  (wb_data),
        .kill_hit (kill_valid && kill_sel == IDX),
        .inc      (fire && issue_dst == IDX),
        .q        (rf[r]),
        .busy     (busy[r]),
        .full     (full[r]),
        .under    (under[r])
      );
    end else begin : g_dead
      assign live[r]  = 1'b0;
      assign rf[r]    = '0;
      assign busy[r]  = 1'b0;
      assign full[r]  = 1'b0;
      assign under[r] = 1'b0;
    end
  end

  assign rd1_data = (rst && wb_we && wb_sel == rd1_sel && live[rd1_sel]) ? wb_data : rf[rd1_sel];
  assign rd2_data = (rst && wb_we && wb_sel == rd2_sel && live[rd2_sel]) ? wb_data : rf[rd2_sel];

  assign stall = issue_valid && ((src1_used && busy[rd1_sel]) ||
                                 (src2_used && busy[rd2_sel]) ||
                                 (issue_we  && full[issue_dst]));
  assign fire  = issue_valid && issue_we && !stall;

  always_ff @(posedge clk or negedge rst)
    if (!rst)         err <= 1'b0;
    else if (|under)  err <= 1'b1;
endmodule

// File: tb/tb_decode_scoreboard_rf.sv
// Scenario bench for decode_scoreboard_rf: default instance plus a ZERO_REG, NREGS=6 instance.
module tb_decode_scoreboard_rf;
  logic        clk = 1'b0, rst = 1'b0;
  logic [2:0]  rd1_sel, rd2_sel, issue_dst, wb_sel, kill_sel;
  logic        src1_used, src2_used, issue_valid, issue_we, wb_we, kill_valid;
  logic [15:0] wb_data, rd1_data, rd2_data, rd1_z, rd2_z;
  logic        stall, err, stall_z, err_z;
  int          nchk = 0, nerr = 0;

  typedef struct {
    logic rst, iv, iwe; logic [2:0] idst;
    logic s1u; logic [2:0] s1; logic s2u; logic [2:0] s2;
    logic wbe; logic [2:0] wbs; logic [15:0] wbd;
    logic kv; logic [2:0] ks;
  } stim_t;
  typedef struct { logic stall, err, c1; logic [15:0] rd1; logic c2; logic [15:0] rd2; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  decode_scoreboard_rf dut (
    .clk(clk), .rst(rst), .rd1_sel(rd1_sel), .rd2_sel(rd2_sel),
    .src1_used(src1_used), .src2_used(src2_used), .rd1_data(rd1_data), .rd2_data(rd2_data),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_dst(issue_dst), .stall(stall),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_data(wb_data),
    .kill_valid(kill_valid), .kill_sel(kill_sel), .err(err));

  decode_scoreboard_rf #(.NREGS(6), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .rd1_sel(rd1_sel), .rd2_sel(rd2_sel),
    .src1_used(src1_used), .src2_used(src2_used), .rd1_data(rd1_z), .rd2_data(rd2_z),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_dst(issue_dst), .stall(stall_z),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_data(wb_data),
    .kill_valid(kill_valid), .kill_sel(kill_sel), .err(err_z));

  function automatic stim_t S(input logic r, iv, iwe, input logic [2:0] idst,
                              input logic s1u, input logic [2:0] s1,
                              input logic s2u, input logic [2:0] s2,
                              input logic wbe, input logic [2:0] wbs, input logic [15:0] wbd,
                              input logic kv, input logic [2:0] ks);
    stim_t s;
    s.rst = r; s.iv = iv; s.iwe = iwe; s.idst = idst; s.s1u = s1u; s.s1 = s1;
    s.s2u = s2u; s.s2 = s2; s.wbe = wbe; s.wbs = wbs; s.wbd = wbd; s.kv = kv; s.ks = ks;
    return s;
  endfunction

  function automatic exp_t E(input logic st, er, c1, input logic [15:0] d1,
                             input logic c2, input logic [15:0] d2);
    exp_t e;
    e.stall = st; e.err = er; e.c1 = c1; e.rd1 = d1; e.c2 = c2; e.rd2 = d2;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; issue_valid = s.iv; issue_we = s.iwe; issue_dst = s.idst;
    src1_used = s.s1u; rd1_sel = s.s1; src2_used = s.s2u; rd2_sel = s.s2;
    wb_we = s.wbe; wb_sel = s.wbs; wb_data = s.wbd; kill_valid = s.kv; kill_sel = s.ks;
  endtask

  task automatic test_reset();
    stim_t st[$]; exp_t ex[$]; exp_t e;
    st.push_back(S(0, 1,0,0, 1,3, 1,5, 0,0,16'h0,      0,0)); ex.push_back(E(0,0, 1,16'h0,    1,16'h0));
    st.push_back(S(1, 0,0,0, 0,3, 0,0, 1,3,16'h3333,   0,0)); ex.push_back(E(0,0, 1,16'h3333, 0,16'h0));
    st.push_back(S(1, 1,1,3, 0,3, 0,0, 0,0,16'h0,      0,0)); ex.push_back(E(0,1, 1,16'h3333, 0,16'h0));
    st.push_back(S(1, 1,1,3, 0,3, 0,0, 0,0,16'h0,      0,0)); ex.push_back(E(0,1, 1,16'h3333, 0,16'h0));
    st.push_back(S(1, 1,0,0, 1,3, 0,0, 0,0,16'h0,      0,0)); ex.push_back(E(1,1, 1,16'h3333, 0,16'h0));
    st.push_back(S(0, 1,0,0, 1,3, 0,0, 0,0,16'h0,      0,0)); ex.push_back(E(0,0, 1,16'h0,    0,16'h0));
    st.push_back(S(1, 1,0,0, 1,3, 0,0, 0,0,16'h0,      0,0)); ex.push_back(E(0,0, 1,16'h0,    0,16'h0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk); e = exp_q.pop_front();
      nchk++; if (stall !== e.stall) begin nerr++; $display("FAIL reset[%0d] stall got %b want %b", i, stall, e.stall); end
      nchk++; if (err !== e.err) begin nerr++; $display("FAIL reset[%0d] err got %b want %b", i, err, e.err); end
      if (e.c1) begin nchk++; if (rd1_data !== e.rd1) begin nerr++; $display("FAIL reset[%0d] rd1 got %h want %h", i, rd1_data, e.rd1); end end
      if (e.c2) begin nchk++; if (rd2_data !== e.rd2) begin nerr++; $display("FAIL reset[%0d] rd2 got %h want %h", i, rd2_data, e.rd2); end end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t st[$]; exp_t ex[$]; exp_t e;
    st.push_back(S(1, 1,1,2, 0,2, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(0,0, 1,16'h0,    0,16'h0));
    st.push_back(S(1, 1,0,0, 1,2, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(1,0, 1,16'h0,    0,16'h0));
    st.push_back(S(1, 1,0,0, 1,2, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(1,0, 1,16'h0,    0,16'h0));
    st.push_back(S(1, 1,0,0, 1,2, 0,0, 1,2,16'hBEEF, 0,0)); ex.push_back(E(0,0, 1,16'hBEEF, 0,16'h0));
    st.push_back(S(1, 0,0,0, 0,2, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(0,0, 1,16'hBEEF, 0,16'h0));
    st.push_back(S(1, 1,0,0, 1,2, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(0,0, 1,16'hBEEF, 0,16'h0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk); e = exp_q.pop_front();
      nchk++; if (stall !== e.stall) begin nerr++; $display("FAIL load_use[%0d] stall got %b want %b", i, stall, e.stall); end
      nchk++; if (err !== e.err) begin nerr++; $display("FAIL load_use[%0d] err got %b want %b", i, err, e.err); end
      if (e.c1) begin nchk++; if (rd1_data !== e.rd1) begin nerr++; $display("FAIL load_use[%0d] rd1 got %h want %h", i, rd1_data, e.rd1); end end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overflow();
    stim_t st[$]; exp_t ex[$]; exp_t e;
    repeat (3) begin
      st.push_back(S(1, 1,1,5, 0,5, 0,0, 0,0,16'h0, 0,0)); ex.push_back(E(0,0, 1,16'h0, 0,16'h0));
    end
    st.push_back(S(1, 1,1,5, 0,5, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(1,0, 1,16'h0,    0,16'h0));
    st.push_back(S(1, 1,1,5, 0,5, 0,0, 1,5,16'h5555, 0,0)); ex.push_back(E(0,0, 1,16'h5555, 0,16'h0));
    st.push_back(S(1, 1,1,5, 0,5, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(1,0, 1,16'h5555, 0,16'h0));
    repeat (3) begin
      st.push_back(S(1, 0,0,0, 0,5, 0,0, 1,5,16'h5555, 0,0)); ex.push_back(E(0,0, 1,16'h5555, 0,16'h0));
    end
    st.push_back(S(1, 1,0,0, 1,5, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(0,0, 1,16'h5555, 0,16'h0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk); e = exp_q.pop_front();
      nchk++; if (stall !== e.stall) begin nerr++; $display("FAIL overflow[%0d] stall got %b want %b", i, stall, e.stall); end
      nchk++; if (err !== e.err) begin nerr++; $display("FAIL overflow[%0d] err got %b want %b", i, err, e.err); end
      if (e.c1) begin nchk++; if (rd1_data !== e.rd1) begin nerr++; $display("FAIL overflow[%0d] rd1 got %h want %h", i, rd1_data, e.rd1); end end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_same_cycle();
    stim_t st[$]; exp_t ex[$]; exp_t e;
    st.push_back(S(1, 1,1,1, 0,1, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(0,0, 0,16'h0, 0,16'h0));
    st.push_back(S(1, 1,1,1, 1,6, 0,0, 1,1,16'h1111, 0,0)); ex.push_back(E(0,0, 1,16'h0, 0,16'h0));
    st.push_back(S(1, 1,0,0, 0,0, 1,1, 0,0,16'h0,    0,0)); ex.push_back(E(1,0, 0,16'h0, 1,16'h1111));
    st.push_back(S(1, 1,0,0, 0,0, 1,1, 1,1,16'h2222, 0,0)); ex.push_back(E(0,0, 0,16'h0, 1,16'h2222));
    st.push_back(S(1, 1,0,0, 0,0, 1,1, 0,0,16'h0,    0,0)); ex.push_back(E(0,0, 0,16'h0, 1,16'h2222));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk); e = exp_q.pop_front();
      nchk++; if (stall !== e.stall) begin nerr++; $display("FAIL same_cycle[%0d] stall got %b want %b", i, stall, e.stall); end
      nchk++; if (err !== e.err) begin nerr++; $display("FAIL same_cycle[%0d] err got %b want %b", i, err, e.err); end
      if (e.c1) begin nchk++; if (rd1_data !== e.rd1) begin nerr++; $display("FAIL same_cycle[%0d] rd1 got %h want %h", i, rd1_data, e.rd1); end end
      if (e.c2) begin nchk++; if (rd2_data !== e.rd2) begin nerr++; $display("FAIL same_cycle[%0d] rd2 got %h want %h", i, rd2_data, e.rd2); end end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    stim_t st[$]; exp_t ex[$]; exp_t e;
    st.push_back(S(1, 1,1,4, 0,4, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(0,0, 1,16'h0,    0,16'h0));
    st.push_back(S(1, 1,1,4, 0,4, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(0,0, 1,16'h0,    0,16'h0));
    st.push_back(S(1, 0,0,0, 0,4, 0,0, 1,4,16'h4444, 1,4)); ex.push_back(E(0,0, 1,16'h4444, 0,16'h0));
    st.push_back(S(1, 1,0,0, 1,4, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(0,0, 1,16'h4444, 0,16'h0));
    st.push_back(S(1, 0,0,0, 0,4, 0,0, 0,0,16'h0,    1,4)); ex.push_back(E(0,0, 1,16'h4444, 0,16'h0));
    st.push_back(S(1, 1,0,0, 1,4, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(0,1, 1,16'h4444, 0,16'h0));
    st.push_back(S(1, 0,0,0, 0,0, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(0,1, 0,16'h0,    0,16'h0));
    st.push_back(S(1, 0,0,0, 0,0, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(0,1, 0,16'h0,    0,16'h0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk); e = exp_q.pop_front();
      nchk++; if (stall !== e.stall) begin nerr++; $display("FAIL flush[%0d] stall got %b want %b", i, stall, e.stall); end
      nchk++; if (err !== e.err) begin nerr++; $display("FAIL flush[%0d] err got %b want %b", i, err, e.err); end
      if (e.c1) begin nchk++; if (rd1_data !== e.rd1) begin nerr++; $display("FAIL flush[%0d] rd1 got %h want %h", i, rd1_data, e.rd1); end end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_reg();
    stim_t st[$]; exp_t ex[$]; exp_t e;
    st.push_back(S(0, 0,0,0, 0,0, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(0,0, 1,16'h0,    1,16'h0));
    st.push_back(S(1, 0,0,0, 0,0, 0,0, 1,0,16'h1234, 0,0)); ex.push_back(E(0,0, 1,16'h0,    0,16'h0));
    st.push_back(S(1, 1,1,0, 0,0, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(0,0, 1,16'h0,    0,16'h0));
    st.push_back(S(1, 1,0,0, 1,0, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(0,0, 1,16'h0,    0,16'h0));
    st.push_back(S(1, 0,0,0, 0,7, 0,6, 1,7,16'h7777, 1,6)); ex.push_back(E(0,0, 1,16'h0,    1,16'h0));
    st.push_back(S(1, 1,1,7, 1,7, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(0,0, 1,16'h0,    0,16'h0));
    st.push_back(S(1, 1,0,0, 1,7, 1,6, 0,0,16'h0,    0,0)); ex.push_back(E(0,0, 1,16'h0,    1,16'h0));
    st.push_back(S(1, 1,1,5, 0,5, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(0,0, 1,16'h0,    0,16'h0));
    st.push_back(S(1, 1,0,0, 1,5, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(1,0, 1,16'h0,    0,16'h0));
    st.push_back(S(1, 1,0,0, 1,5, 0,0, 1,5,16'h0505, 0,0)); ex.push_back(E(0,0, 1,16'h0505, 0,16'h0));
    st.push_back(S(1, 0,0,0, 0,5, 0,0, 0,0,16'h0,    0,0)); ex.push_back(E(0,0, 1,16'h0505, 0,16'h0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk); e = exp_q.pop_front();
      nchk++; if (stall_z !== e.stall) begin nerr++; $display("FAIL zero_reg[%0d] stall got %b want %b", i, stall_z, e.stall); end
      nchk++; if (err_z !== e.err) begin nerr++; $display("FAIL zero_reg[%0d] err got %b want %b", i, err_z, e.err); end
      if (e.c1) begin nchk++; if (rd1_z !== e.rd1) begin nerr++; $display("FAIL zero_reg[%0d] rd1 got %h want %h", i, rd1_z, e.rd1); end end
      if (e.c2) begin nchk++; if (rd2_z !== e.rd2) begin nerr++; $display("FAIL zero_reg[%0d] rd2 got %h want %h", i, rd2_z, e.rd2); end end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    apply(S(0, 0,0,0, 0,0, 0,0, 0,0,16'h0, 0,0));
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_overflow();
    test_same_cycle();
    test_flush();
    test_zero_reg();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
